// File: rtl/stump_mem_arbiter_if.sv
// Bundle of requester, memory and status signals for the Stump memory arbiter.
// The arbiter takes the slave view; the surrounding system takes the master view.
interface stump_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_wen;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              ext_req;
  logic              ext_wen;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              cpu_ack;
  logic              cpu_err;
  logic              ext_ack;
  logic              ext_err;
  logic [DATA_W-1:0] rd_data;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    input  ext_req, ext_wen, ext_addr, ext_wdata,
    input  mem_rdata, mem_ack,
    output cpu_ack, cpu_err, ext_ack, ext_err, rd_data,
    output mem_ren, mem_wen, mem_addr, mem_wdata, busy
  );

  modport master (
    output cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    output ext_req, ext_wen, ext_addr, ext_wdata,
    output mem_rdata, mem_ack,
    input  cpu_ack, cpu_err, ext_ack, ext_err, rd_data,
    input  mem_ren, mem_wen, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/stump_mem_arbiter.sv
// Two-requester memory arbiter (Stump core vs. external debug/DMA port) with
// starvation guard for the external side and a per-transaction ack timeout.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no transaction; arbitrate pending requests each cycle
// CPU_BUSY | core transaction on the memory bus, waiting for mem_ack
// EXT_BUSY | external transaction on the memory bus, waiting for mem_ack
module stump_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input logic            clk,
  input logic            rst,
  stump_mem_arbiter_if.slave bus
);

  localparam int SW_RAW = $clog2(STARVE_LIMIT + 1);
  localparam int SW     = (SW_RAW > 3) ? SW_RAW : 3;
  localparam int CW     = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_BUSY = 2'd1,
    EXT_BUSY = 2'd2
  } state_t;

  state_t          state;
  logic [SW-1:0]   streak;
  logic [CW-1:0]   cnt;

  logic in_busy;
  logic hit_timeout;
  logic done;
  logic starved;
  logic pick_ext;

  assign in_busy     = (state == CPU_BUSY) || (state == EXT_BUSY);
  assign hit_timeout = (cnt == CW'(TIMEOUT - 1));
  assign done        = in_busy && (bus.mem_ack || hit_timeout);
  assign starved     = (streak == SW'(STARVE_LIMIT));
  // External side wins only when alone or when the core has used up its streak.
  assign pick_ext    = bus.ext_req && (!bus.cpu_req || starved);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      streak        <= '0;
      cnt           <= '0;
      bus.mem_ren   <= 1'b0;
      bus.mem_wen   <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req || bus.ext_req) begin
            cnt <= '0;
            if (pick_ext) begin
              state         <= EXT_BUSY;
              streak        <= '0;
              bus.mem_addr  <= bus.ext_addr;
              bus.mem_wdata <= bus.ext_wdata;
              bus.mem_wen   <= bus.ext_wen;
              bus.mem_ren   <= !bus.ext_wen;
            end else begin
              state         <= CPU_BUSY;
              if (bus.ext_req && !starved) begin
                streak <= streak + SW'(1);
              end
              bus.mem_addr  <= bus.cpu_addr;
              bus.mem_wdata <= bus.cpu_wdata;
              bus.mem_wen   <= bus.cpu_wen;
              bus.mem_ren   <= !bus.cpu_wen;
            end
          end
        end
        CPU_BUSY, EXT_BUSY: begin
          if (done) begin
            state       <= IDLE;
            bus.mem_ren <= 1'b0;
            bus.mem_wen <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state       <= IDLE;
          bus.mem_ren <= 1'b0;
          bus.mem_wen <= 1'b0;
        end
      endcase
    end
  end

  // Completion is reported in the same cycle mem_ack (or the timeout) is seen.
  assign bus.cpu_ack = (state == CPU_BUSY) && done;
  assign bus.ext_ack = (state == EXT_BUSY) && done;
  assign bus.cpu_err = (state == CPU_BUSY) && !bus.mem_ack && hit_timeout;
  assign bus.ext_err = (state == EXT_BUSY) && !bus.mem_ack && hit_timeout;
  assign bus.rd_data = (in_busy && bus.mem_ack) ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.busy    = in_busy;

endmodule

// File: tb/tb_stump_mem_arbiter.sv
// Scoreboard bench for stump_mem_arbiter: random requesters and a random-latency
// memory, checked against a grant/timeout reference model plus directed cases.
module tb_stump_mem_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LIM = 4;
  localparam int TO  = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stump_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  stump_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // requester 0 = cpu, 1 = ext
  logic        req [2];
  logic        wen [2];
  logic [15:0] addr [2];
  logic [15:0] wdata [2];
  logic        m_ack;
  logic [15:0] m_rdata;

  assign bus.cpu_req   = req[0];
  assign bus.cpu_wen   = wen[0];
  assign bus.cpu_addr  = addr[0];
  assign bus.cpu_wdata = wdata[0];
  assign bus.ext_req   = req[1];
  assign bus.ext_wen   = wen[1];
  assign bus.ext_addr  = addr[1];
  assign bus.ext_wdata = wdata[1];
  assign bus.mem_ack   = m_ack;
  assign bus.mem_rdata = m_rdata;

  int          p_start [2];
  int          p_drop [2];
  int          p_again [2];
  bit          fix_en [2];
  logic        fix_wen [2];
  logic [15:0] fix_addr [2];
  logic [15:0] fix_wdata [2];
  bit          pend [2];
  bit          granted [2];
  bit          acked [2];
  int          force_lat = -1;
  int          spur_pct = 0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    int          who;
    bit          err;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  int   order[$];
  logic [15:0] mem_arr [logic [15:0]];

  bit          m_busy = 1'b0;
  int          m_streak = 0;
  int          pred_who = 0;
  int          who_g;
  logic        exp_wen;
  logic [15:0] exp_addr;
  logic [15:0] exp_wdata;
  int          exp_end = -1;

  bit          in_tx = 1'b0;
  int          wcnt;
  int          lat;
  int          end_i;
  int          kpick;
  bit          tx_err;
  logic [15:0] tx_rdata;
  int          who_m;
  logic [1:0]  ack_exp;
  exp_t        e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] rd_mem(input logic [15:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : 16'h0000;
  endfunction

  task automatic new_req(input int r);
    req[r]  = 1'b1;
    pend[r] = 1'b1;
    if (fix_en[r]) begin
      wen[r] = fix_wen[r]; addr[r] = fix_addr[r]; wdata[r] = fix_wdata[r];
    end else begin
      wen[r] = 1'($urandom); addr[r] = 16'($urandom % 16); wdata[r] = 16'($urandom);
    end
  endtask

  always @(posedge clk) cyc++;

  // requester agents
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      for (int r = 0; r < 2; r++) begin
        if (acked[r]) begin
          acked[r] = 1'b0; granted[r] = 1'b0; pend[r] = 1'b0;
          if (int'($urandom % 100) < p_again[r]) new_req(r);
          else req[r] = 1'b0;
        end else if (!pend[r]) begin
          if (int'($urandom % 100) < p_start[r]) new_req(r);
        end else if (granted[r] && req[r] && int'($urandom % 100) < p_drop[r]) begin
          req[r] = 1'b0;
        end
      end
    end
  end

  // memory responder: picks a latency per transaction and pushes the expected completion
  always @(posedge clk) begin
    #1;
    if (rst) begin
      in_tx = 1'b0; m_ack = 1'b0;
    end else if (bus.mem_ren || bus.mem_wen) begin
      if (!in_tx) begin
        in_tx = 1'b1; wcnt = 0;
        kpick = int'($urandom % 8);
        if (force_lat >= 0) lat = force_lat;
        else lat = (kpick < 4) ? kpick : (kpick == 4) ? 1 : (kpick == 5) ? 14 : (kpick == 6) ? 15 : 99;
        tx_err   = (lat > TO - 1);
        end_i    = tx_err ? TO - 1 : lat;
        exp_end  = cyc + end_i;
        tx_rdata = bus.mem_wen ? 16'($urandom) : rd_mem(bus.mem_addr);
        sb.push_back('{pred_who, tx_err, tx_err ? 16'h0000 : tx_rdata, exp_end});
      end
      m_ack   = (wcnt == lat);
      m_rdata = m_ack ? tx_rdata : 16'($urandom);
      if (cyc == exp_end) begin
        in_tx = 1'b0;
        if (m_ack && bus.mem_wen) mem_arr[bus.mem_addr] = bus.mem_wdata;
      end
      wcnt++;
    end else begin
      in_tx   = 1'b0;
      m_ack   = (int'($urandom % 100) < spur_pct);
      m_rdata = 16'($urandom);
    end
  end

  // reference model: grant decisions and memory-bus contents
  always @(negedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_streak = 0;
      for (int r = 0; r < 2; r++) begin
        granted[r] = 1'b0; acked[r] = 1'b0;
        if (!req[r]) pend[r] = 1'b0;
      end
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_strobes", 32'({bus.mem_ren, bus.mem_wen}), 0);
      chk("rst_addr_data", 32'({bus.mem_addr, bus.mem_wdata}), 0);
      chk("rst_acks", 32'({bus.cpu_ack, bus.ext_ack, bus.cpu_err, bus.ext_err}), 0);
      chk("rst_rd_data", 32'(bus.rd_data), 0);
    end else if (!m_busy) begin
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_strobes", 32'({bus.mem_ren, bus.mem_wen}), 0);
      who_g = -1;
      if (req[0] && req[1]) who_g = (m_streak == LIM) ? 1 : 0;
      else if (req[0]) who_g = 0;
      else if (req[1]) who_g = 1;
      if (who_g >= 0) begin
        if (who_g == 0 && req[1]) m_streak = (m_streak + 1 > LIM) ? LIM : m_streak + 1;
        if (who_g == 1) m_streak = 0;
        pred_who  = who_g;
        exp_wen   = wen[who_g];
        exp_addr  = addr[who_g];
        exp_wdata = wdata[who_g];
        granted[who_g] = 1'b1;
        m_busy = 1'b1;
      end
    end else begin
      chk("busy_flag", 32'(bus.busy), 1);
      chk("busy_strobes", 32'({bus.mem_ren, bus.mem_wen}), 32'({!exp_wen, exp_wen}));
      chk("busy_addr", 32'(bus.mem_addr), 32'(exp_addr));
      chk("busy_wdata", 32'(bus.mem_wdata), 32'(exp_wdata));
      if (cyc == exp_end) m_busy = 1'b0;
    end
  end

  // monitor: pops the scoreboard whenever an ack is presented
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      chk("both_acks", 32'(bus.cpu_ack & bus.ext_ack), 0);
      chk("cpu_err_alone", 32'(bus.cpu_err & !bus.cpu_ack), 0);
      chk("ext_err_alone", 32'(bus.ext_err & !bus.ext_ack), 0);
      if (bus.cpu_ack || bus.ext_ack) begin
        who_m = bus.ext_ack ? 1 : 0;
        order.push_back(who_m);
        chk("ack_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("ack_who", 32'(who_m), 32'(e.who));
          chk("ack_err", 32'(who_m == 1 ? bus.ext_err : bus.cpu_err), 32'(e.err));
          chk("ack_rd_data", 32'(bus.rd_data), 32'(e.rdata));
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        end
        acked[who_m] = 1'b1;
      end else begin
        chk("noack_rd_data", 32'(bus.rd_data), 0);
        if (sb.size() != 0 && cyc >= sb[0].cyc) begin
          ack_exp = (sb[0].who == 0) ? 2'b10 : 2'b01;
          chk("ack_missing", 32'({bus.cpu_ack, bus.ext_ack}), 32'(ack_exp));
          acked[sb[0].who] = 1'b1;
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic quiesce();
    int k;
    for (int r = 0; r < 2; r++) begin p_start[r] = 0; p_again[r] = 0; p_drop[r] = 0; end
    k = 0;
    while ((pend[0] || pend[1] || m_busy) && k < 200) begin @(negedge clk); k++; end
    chk("quiesce", 32'(pend[0] || pend[1] || m_busy), 0);
    @(posedge clk); #2;
    for (int r = 0; r < 2; r++) fix_en[r] = 1'b0;
    force_lat = -1; spur_pct = 0;
  endtask

  initial begin : main
    int n_ren, n_ack, n_busy, n;
    logic [15:0] cap;
    logic er;
    bit seen;
    int pat [10];
    pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int r = 0; r < 2; r++) begin
      req[r] = 1'b0; wen[r] = 1'b0; addr[r] = '0; wdata[r] = '0;
      p_start[r] = 0; p_drop[r] = 0; p_again[r] = 0; fix_en[r] = 1'b0;
      fix_wen[r] = 1'b0; fix_addr[r] = '0; fix_wdata[r] = '0;
      pend[r] = 1'b0; granted[r] = 1'b0; acked[r] = 1'b0;
    end
    m_ack = 1'b0; m_rdata = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_mem", 32'({bus.mem_ren, bus.mem_wen, bus.mem_addr}), 0);
    rst = 1'b0;

    // single read, two wait states
    mem_arr[16'h0010] = 16'hBEEF;
    fix_en[0] = 1'b1; fix_wen[0] = 1'b0; fix_addr[0] = 16'h0010; force_lat = 2;
    p_start[0] = 100;
    @(posedge clk); #2 p_start[0] = 0;
    n_ren = 0; n_ack = 0; cap = '0;
    repeat (12) begin
      @(negedge clk);
      if (bus.mem_ren) n_ren++;
      if (bus.cpu_ack) begin n_ack++; cap = bus.rd_data; end
    end
    chk("rd_ren_cycles", 32'(n_ren), 3);
    chk("rd_ack_pulses", 32'(n_ack), 1);
    chk("rd_data_beef", 32'(cap), 32'h0000BEEF);
    quiesce();

    // fairness under continuous contention
    do_reset();
    force_lat = 0;
    order.delete();
    for (int r = 0; r < 2; r++) begin p_start[r] = 100; p_again[r] = 100; end
    n = 0;
    while (order.size() < 10 && n < 200) begin @(negedge clk); n++; end
    chk("fair_count", 32'(order.size() >= 10), 1);
    for (int i = 0; i < 10; i++)
      if (i < order.size()) chk($sformatf("fair_grant_%0d", i), 32'(order[i]), 32'(pat[i]));
    quiesce();

    // external write that never completes
    do_reset();
    fix_en[1] = 1'b1; fix_wen[1] = 1'b1; fix_addr[1] = 16'h00FF; fix_wdata[1] = 16'h1234;
    force_lat = 99; p_start[1] = 100;
    @(posedge clk); #2 p_start[1] = 0;
    n = 0; seen = 1'b0; er = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.busy) n++;
      if (bus.ext_ack) begin seen = 1'b1; er = bus.ext_err; end
    end
    chk("to_seen", 32'(seen), 1);
    chk("to_busy_cycles", 32'(n), 15);
    chk("to_err", 32'(er), 1);
    @(negedge clk);
    chk("to_idle_after", 32'(bus.busy), 0);
    quiesce();

    // reset in the middle of a core transaction
    fix_en[0] = 1'b1; fix_wen[0] = 1'b0; fix_addr[0] = 16'h0033; force_lat = 99;
    p_start[0] = 100;
    n = 0;
    while (!bus.busy && n < 20) begin @(negedge clk); n++; end
    chk("mid_rst_started", 32'(bus.busy), 1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_mem", 32'({bus.mem_ren, bus.mem_wen, bus.mem_addr}), 0);
    chk("mid_rst_ack", 32'({bus.cpu_ack, bus.cpu_err}), 0);
    p_start[0] = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("regrant_busy", 32'(bus.busy), 1);
    chk("regrant_ren", 32'(bus.mem_ren), 1);
    chk("regrant_addr", 32'(bus.mem_addr), 32'h0033);
    quiesce();

    // core drops its request while the memory is still working
    fix_en[0] = 1'b1; fix_wen[0] = 1'b0; fix_addr[0] = 16'h0005; force_lat = 3;
    p_drop[0] = 100; p_start[0] = 100;
    @(posedge clk); #2 p_start[0] = 0;
    n_ack = 0; n_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.cpu_ack) n_ack++;
      if (bus.busy) n_busy++;
    end
    chk("drop_ack_pulses", 32'(n_ack), 1);
    chk("drop_busy_cycles", 32'(n_busy), 4);
    quiesce();

    // spurious mem_ack with nobody requesting
    spur_pct = 100;
    n_ack = 0; n_busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.cpu_ack || bus.ext_ack) n_ack++;
      if (bus.busy) n_busy++;
    end
    chk("spur_acks", 32'(n_ack), 0);
    chk("spur_busy", 32'(n_busy), 0);
    quiesce();

    // random traffic
    for (int r = 0; r < 2; r++) begin p_start[r] = 40; p_drop[r] = 10; p_again[r] = 50; end
    spur_pct = 10;
    repeat (3000) @(posedge clk);
    quiesce();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
